// File: rtl/cpu_bus_capture_pkg.sv
// Shared types and constants for the NES CPU bus capture slice.
// Holds the capture FSM state type, region bases and defaults.
`timescale 1ns/1ps
package fc_bus_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    localparam logic [15:0] REG_PRG  = 16'h8000;
    localparam logic [15:0] REG_WRAM = 16'h6000;
    localparam logic [15:0] REG_EXP  = 16'h4020;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT        = 3;
    localparam int DEF_MIN_HIGH    = 4;
    localparam int DEF_TIMEOUT     = 255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cpu_bus_capture_if.sv
// CPU cartridge bus plus captured-strobe outputs, bundled.
// master: drives the raw CPU bus; slave: the capture block.
`timescale 1ns/1ps
interface cpu_bus_capture_if;

    logic        m2;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data;

    logic        wr_stb;
    logic        rd_stb;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        m2_alive;
    logic [7:0]  runt_cnt;

    modport master (
        output m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data,
        input  wr_stb, rd_stb, bus_addr, bus_data, m2_alive, runt_cnt
    );

    modport slave (
        input  m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data,
        output wr_stb, rd_stb, bus_addr, bus_data, m2_alive, runt_cnt
    );

endinterface

// File: rtl/cpu_bus_capture_sync_filter.sv
// Synchronizer plus level filter for one asynchronous bit.
// Ports: clk, rst_n, d (async in), s (synced), f (filtered level).
`timescale 1ns/1ps
module sync_filter #(
    parameter int STAGES = 2,
    parameter int FILT   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic f
);

    localparam int CW = $clog2(FILT + 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              f_q, f_d;

    // cnt counts consecutive samples that disagree with f; any
    // agreeing sample restarts it, so short glitches never flip f.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        f_d    = f_q;
        cnt_d  = '0;
        if (sync_q[STAGES-1] != f_q) begin
            if (cnt_q == CW'(FILT - 1)) begin
                f_d = sync_q[STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            f_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            f_q    <= f_d;
        end
    end

    assign s = sync_q[STAGES-1];
    assign f = f_q;

endmodule

// File: rtl/cpu_bus_capture.sv
// Brings the async NES CPU bus into osc50 and emits one strobe per cycle.
// Ports: osc50, m2_rst (async low), bus (slave: CPU bus in, strobes out).
`timescale 1ns/1ps
module cpu_bus_capture
    import fc_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT        = DEF_FILT,
    parameter int MIN_HIGH    = DEF_MIN_HIGH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              osc50,
    input  logic              m2_rst,
    cpu_bus_capture_if.slave  bus
);

    localparam int PW     = 25;
    localparam int HCW    = $clog2(MIN_HIGH + 1);
    localparam int WDW    = $clog2(TIMEOUT + 1);
    localparam int SETTLE = SYNC_STAGES + FILT;
    localparam int SCW    = $clog2(SETTLE + 1);

    logic m2_s;
    logic m2_f;

    sync_filter #(
        .STAGES (SYNC_STAGES),
        .FILT   (FILT)
    ) u_m2 (
        .clk   (osc50),
        .rst_n (m2_rst),
        .d     (bus.m2),
        .s     (m2_s),
        .f     (m2_f)
    );

    // Side signals go through the same depth as m2 so that a
    // sample of m2_s lines up with the bus values it qualifies.
    logic [SYNC_STAGES-1:0][PW-1:0] pipe_q, pipe_d;
    logic                           romsel_s;
    logic                           rw_s;
    logic [14:0]                    addr_s;
    logic [7:0]                     data_s;

    always_comb begin
        pipe_d[0] = {bus.romsel, bus.cpu_rw_in,
                     bus.cpu_addr_in, bus.cpu_data};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign {romsel_s, rw_s, addr_s, data_s} = pipe_q[SYNC_STAGES-1];

    state_t          state_q, state_d;
    logic [HCW-1:0]  high_cnt_q, high_cnt_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic [15:0]     cap_addr_q, cap_addr_d;
    logic [7:0]      cap_data_q, cap_data_d;
    logic            cap_rw_q, cap_rw_d;
    logic [15:0]     bus_addr_q, bus_addr_d;
    logic [7:0]      bus_data_q, bus_data_d;
    logic            wr_stb_q, wr_stb_d;
    logic            rd_stb_q, rd_stb_d;
    logic            alive_q, alive_d;
    logic [7:0]      runt_q, runt_d;
    logic            timeout;

    assign timeout = (state_q != S_COMMIT) &&
                     (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        settle_d   = settle_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_rw_d   = cap_rw_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        alive_d    = alive_q;
        runt_d     = runt_q;

        if (state_q == S_COMMIT) begin
            wd_d = '0;
        end else if (wd_q != WDW'(TIMEOUT)) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = wd_q;
        end

        unique case (state_q)
            // Leave only after M2 has been seen low for longer than
            // the sync+filter depth; this rejects the zeroed
            // synchronizer right after reset release.
            S_INIT: begin
                if (m2_s || m2_f) begin
                    settle_d = '0;
                end else if (settle_q == SCW'(SETTLE)) begin
                    settle_d = '0;
                    state_d  = S_LOW;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_LOW: begin
                if (m2_f) begin
                    high_cnt_d = '0;
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                if (m2_s) begin
                    cap_addr_d = {~romsel_s, addr_s};
                    cap_data_d = data_s;
                    cap_rw_d   = rw_s;
                end
                if (m2_f) begin
                    if (high_cnt_q != HCW'(MIN_HIGH)) begin
                        high_cnt_d = high_cnt_q + 1'b1;
                    end
                end else if (high_cnt_q >= HCW'(MIN_HIGH)) begin
                    bus_addr_d = cap_addr_q;
                    bus_data_d = cap_data_q;
                    wr_stb_d   = ~cap_rw_q;
                    rd_stb_d   = cap_rw_q;
                    alive_d    = 1'b1;
                    state_d    = S_COMMIT;
                end else begin
                    runt_d  = sat_inc8(runt_q);
                    state_d = S_LOW;
                end
            end
            S_COMMIT: begin
                state_d = S_LOW;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Watchdog expiry drops any partial or pending cycle.
        if (timeout) begin
            state_d    = S_INIT;
            settle_d   = '0;
            alive_d    = 1'b0;
            wr_stb_d   = 1'b0;
            rd_stb_d   = 1'b0;
            bus_addr_d = bus_addr_q;
            bus_data_d = bus_data_q;
        end
    end

    always_ff @(posedge osc50 or negedge m2_rst) begin
        if (!m2_rst) begin
            pipe_q     <= '0;
            state_q    <= S_INIT;
            high_cnt_q <= '0;
            wd_q       <= '0;
            settle_q   <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_rw_q   <= 1'b1;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            alive_q    <= 1'b0;
            runt_q     <= '0;
        end else begin
            pipe_q     <= pipe_d;
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            wd_q       <= wd_d;
            settle_q   <= settle_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_rw_q   <= cap_rw_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            alive_q    <= alive_d;
            runt_q     <= runt_d;
        end
    end

    assign bus.wr_stb   = wr_stb_q;
    assign bus.rd_stb   = rd_stb_q;
    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_data = bus_data_q;
    assign bus.m2_alive = alive_q;
    assign bus.runt_cnt = runt_q;

endmodule

// File: tb/tb_cpu_bus_capture.sv
// Directed bench for cpu_bus_capture.
// Drives CPU bus cycles off the clock grid and checks strobes.
`timescale 1ns/1ps
module tb_cpu_bus_capture;

    logic osc50  = 1'b0;
    logic m2_rst = 1'b0;

    cpu_bus_capture_if bus ();

    cpu_bus_capture dut (
        .osc50  (osc50),
        .m2_rst (m2_rst),
        .bus    (bus)
    );

    always #10 osc50 = ~osc50;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_both = 0;
    int f_tog  = 0;
    int last_stb_cyc = 0;
    logic [15:0] stb_addr = '0;
    logic [7:0]  stb_data = '0;
    logic        f_prev   = 1'b0;
    int fall_cyc = 0;

    always @(posedge osc50) cyc <= cyc + 1;

    always @(negedge osc50) begin
        f_prev <= dut.m2_f;
        if (dut.m2_f !== f_prev) f_tog <= f_tog + 1;
        if (bus.wr_stb && bus.rd_stb) n_both <= n_both + 1;
        if (bus.wr_stb) n_wr <= n_wr + 1;
        if (bus.rd_stb) n_rd <= n_rd + 1;
        if (bus.wr_stb || bus.rd_stb) begin
            last_stb_cyc <= cyc;
            stb_addr     <= bus.bus_addr;
            stb_data     <= bus.bus_data;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All delays are even and start at an odd time, so bus edges
    // never coincide with an osc50 edge.
    task automatic bus_cycle(input logic        a15,
                             input logic        rw,
                             input logic [14:0] addr,
                             input logic [7:0]  data,
                             input int          high_ns,
                             input int          low_ns,
                             input logic        late_ff);
        bus.cpu_addr_in = addr;
        bus.cpu_rw_in   = rw;
        bus.cpu_data    = data;
        bus.m2          = 1'b1;
        bus.romsel      = ~a15;
        #(high_ns);
        bus.m2     = 1'b0;
        bus.romsel = 1'b1;
        fall_cyc   = cyc;
        if (late_ff) begin
            #10;
            bus.cpu_data = 8'hFF;
            #(low_ns - 10);
        end else begin
            #(low_ns);
        end
    endtask

    int wr0, rd0, ft0, lat;

    initial begin
        bus.m2          = 1'b0;
        bus.romsel      = 1'b1;
        bus.cpu_rw_in   = 1'b1;
        bus.cpu_addr_in = '0;
        bus.cpu_data    = '0;

        #5;
        chk("rst_wr",    32'(bus.wr_stb),   0);
        chk("rst_rd",    32'(bus.rd_stb),   0);
        chk("rst_addr",  32'(bus.bus_addr), 0);
        chk("rst_data",  32'(bus.bus_data), 0);
        chk("rst_alive", 32'(bus.m2_alive), 0);
        chk("rst_runt",  32'(bus.runt_cnt), 0);
        #100;
        m2_rst = 1'b1;
        @(posedge osc50);
        #3;
        #400;

        // Write $8000 = 03
        wr0 = n_wr; rd0 = n_rd;
        bus_cycle(1'b1, 1'b0, 15'h0000, 8'h03, 280, 280, 1'b0);
        chk("w1_wr",    32'(n_wr - wr0), 1);
        chk("w1_rd",    32'(n_rd - rd0), 0);
        chk("w1_addr",  32'(stb_addr),   32'h8000);
        chk("w1_data",  32'(stb_data),   32'h03);
        chk("w1_alive", 32'(bus.m2_alive), 1);
        lat = last_stb_cyc - fall_cyc;
        chk("w1_lat",   32'(lat >= 5 && lat <= 7), 1);

        // Read $6123
        wr0 = n_wr; rd0 = n_rd;
        bus_cycle(1'b0, 1'b1, 15'h6123, 8'h77, 280, 280, 1'b0);
        chk("r1_rd",   32'(n_rd - rd0), 1);
        chk("r1_wr",   32'(n_wr - wr0), 0);
        chk("r1_addr", 32'(stb_addr),   32'h6123);
        chk("r1_hold", 32'(bus.bus_addr), 32'h6123);

        // 30 ns glitch, then a runt that passes the filter but is short
        wr0 = n_wr; rd0 = n_rd; ft0 = f_tog;
        bus.m2 = 1'b1; #30; bus.m2 = 1'b0; #200;
        chk("gl_ftog", 32'(f_tog - ft0), 0);
        chk("gl_runt", 32'(bus.runt_cnt), 0);
        bus.m2 = 1'b1; #60; bus.m2 = 1'b0; #300;
        chk("rt_runt", 32'(bus.runt_cnt), 1);
        chk("rt_stb",  32'(n_wr - wr0 + n_rd - rd0), 0);

        // MIN_HIGH boundary: 4 samples rejected, 5 accepted
        wr0 = n_wr; rd0 = n_rd;
        bus_cycle(1'b0, 1'b0, 15'h4020, 8'h11, 80, 280, 1'b0);
        chk("b4_runt", 32'(bus.runt_cnt), 2);
        chk("b4_stb",  32'(n_wr - wr0 + n_rd - rd0), 0);
        bus_cycle(1'b0, 1'b0, 15'h4020, 8'h22, 100, 280, 1'b0);
        chk("b5_wr",   32'(n_wr - wr0), 1);
        chk("b5_addr", 32'(stb_addr),   32'h4020);
        chk("b5_data", 32'(stb_data),   32'h22);
        chk("b5_runt", 32'(bus.runt_cnt), 2);

        // Data changes after M2 falls
        wr0 = n_wr;
        bus_cycle(1'b1, 1'b0, 15'h0005, 8'h5A, 280, 280, 1'b1);
        chk("ld_wr",   32'(n_wr - wr0), 1);
        chk("ld_addr", 32'(stb_addr),   32'h8005);
        chk("ld_data", 32'(stb_data),   32'h5A);

        // Watchdog: M2 held low
        wr0 = n_wr; rd0 = n_rd;
        repeat (250 - (cyc - last_stb_cyc)) @(posedge osc50);
        #5;
        chk("wd_alive_250", 32'(bus.m2_alive), 1);
        repeat (12) @(posedge osc50);
        #5;
        chk("wd_alive_262", 32'(bus.m2_alive), 0);
        repeat (40) @(posedge osc50);
        #5;
        chk("wd_alive_low", 32'(bus.m2_alive), 0);
        chk("wd_stb",  32'(n_wr - wr0 + n_rd - rd0), 0);
        chk("wd_hold", 32'(bus.bus_addr), 32'h8005);
        bus_cycle(1'b1, 1'b1, 15'h1234, 8'h00, 280, 280, 1'b0);
        chk("wd_rd",    32'(n_rd - rd0), 1);
        chk("wd_addr",  32'(stb_addr),   32'h9234);
        chk("wd_alive", 32'(bus.m2_alive), 1);

        // Reset mid M2-high, released while still high
        wr0 = n_wr; rd0 = n_rd;
        bus.cpu_addr_in = 15'h0042;
        bus.cpu_rw_in   = 1'b0;
        bus.cpu_data    = 8'hA5;
        bus.m2          = 1'b1;
        bus.romsel      = 1'b0;
        #100;
        m2_rst = 1'b0;
        #10;
        chk("mr_wr",    32'(bus.wr_stb),   0);
        chk("mr_addr",  32'(bus.bus_addr), 0);
        chk("mr_data",  32'(bus.bus_data), 0);
        chk("mr_alive", 32'(bus.m2_alive), 0);
        chk("mr_runt",  32'(bus.runt_cnt), 0);
        #40;
        m2_rst = 1'b1;
        #130;
        bus.m2     = 1'b0;
        bus.romsel = 1'b1;
        #280;
        chk("mr_nostb", 32'(n_wr - wr0 + n_rd - rd0), 0);
        bus_cycle(1'b1, 1'b0, 15'h0042, 8'hC3, 280, 280, 1'b0);
        chk("mr_next_wr",   32'(n_wr - wr0), 1);
        chk("mr_next_addr", 32'(stb_addr),   32'h8042);
        chk("mr_next_data", 32'(stb_data),   32'hC3);

        chk("never_both", 32'(n_both), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
